wb_sram_ctrl: RTL and testbench



---
 rtl/sram_pkg.sv | 23 ++
 rtl/sram_rdata_mux.sv | 23 ++
 rtl/wb_sram_ctrl.sv | 171 +++++++++++++++++
 tb/tb_wb_sram_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared constants and FSM state type for the Wishbone-to-SRAM bridge.
// The state enum is also used by the bench to decode the debug state output.
package sram_pkg;

    localparam int SRAM_AW    = 8;
    localparam int SRAM_DW    = 32;
    localparam int SRAM_WORDS = 256;
    localparam int SRAM_BYTES = 1024;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        RD_REQ  = 3'd2,
        RD_DATA = 3'd3,
        RESP    = 3'd4
    } state_t;

    // Width of a bank index; never zero so a single-bank build still has a port.
    function automatic int bank_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sram_rdata_mux.sv
// Picks one macro's 32-bit port-0 read data out of the concatenated bus
// using the bank index registered when the request was accepted.
module sram_rdata_mux
    import sram_pkg::*;
#(
    parameter int NUM_BANKS = 2,
    parameter int BANK_W    = 1
) (
    input  logic [NUM_BANKS*SRAM_DW-1:0] dout,
    input  logic [BANK_W-1:0]            bank,
    output logic [SRAM_DW-1:0]           rdata
);

    always_comb begin
        rdata = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (bank == BANK_W'(b)) begin
                rdata = dout[b*SRAM_DW +: SRAM_DW];
            end
        end
    end

endmodule

// File: rtl/wb_sram_ctrl.sv
// Wishbone B4 classic slave driving port 0 of NUM_BANKS 1 KB SRAM macros.
// Every output is a flop; the FSM state is exported on fsm_state for debug.
module wb_sram_ctrl
    import sram_pkg::*;
#(
    parameter int                NUM_BANKS = 2,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wb_cyc_i,
    input  logic                         wb_stb_i,
    input  logic                         wb_we_i,
    input  logic [ADDR_W-1:0]            wb_adr_i,
    input  logic [SRAM_DW-1:0]           wb_dat_i,
    input  logic [3:0]                   wb_sel_i,
    output logic [SRAM_DW-1:0]           wb_dat_o,
    output logic                         wb_ack_o,
    output logic                         wb_err_o,
    output logic [NUM_BANKS-1:0]         sram_csb0,
    output logic                         sram_web0,
    output logic [7:0]                   sram_wmask0,
    output logic [SRAM_AW-1:0]           sram_addr0,
    output logic [SRAM_DW-1:0]           sram_din0,
    input  logic [NUM_BANKS*SRAM_DW-1:0] sram_dout0,
    output state_t                       fsm_state
);

    localparam int BANK_W = bank_bits(NUM_BANKS);

    // Handshake: a request is taken only in IDLE when cyc&stb are high at the
    // edge; the slave answers with exactly one single-cycle ack or err pulse,
    // and the master may drop cyc before that to abandon the access.

    state_t state, next_state;

    logic [ADDR_W-1:0]   off;
    logic                oor;
    logic [BANK_W-1:0]   req_bank;
    logic [SRAM_AW-1:0]  req_word;
    logic                req;
    logic                unused_off;

    logic [BANK_W-1:0]    bank_q, bank_d;
    logic [SRAM_DW-1:0]   rdata;
    logic [NUM_BANKS-1:0] csb_d;
    logic                 web_d;
    logic [7:0]           wmask_d;
    logic [SRAM_AW-1:0]   addr_d;
    logic [SRAM_DW-1:0]   din_d;
    logic [SRAM_DW-1:0]   dat_d;
    logic                 ack_d;
    logic                 err_d;

    assign off        = wb_adr_i - BASE_ADDR;
    assign oor        = (wb_adr_i < BASE_ADDR) ||
                        (off[ADDR_W-1:10] >= (ADDR_W-10)'(NUM_BANKS));
    assign req_bank   = off[10 +: BANK_W];
    assign req_word   = off[9:2];
    assign req        = wb_cyc_i && wb_stb_i;
    assign unused_off = ^off[1:0];
    assign fsm_state  = state;

    sram_rdata_mux #(
        .NUM_BANKS (NUM_BANKS),
        .BANK_W    (BANK_W)
    ) u_rdata_mux (
        .dout  (sram_dout0),
        .bank  (bank_q),
        .rdata (rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (req) begin
                    if (oor)          next_state = RESP;
                    else if (wb_we_i) next_state = WR;
                    else              next_state = RD_REQ;
                end
            end
            WR:      next_state = wb_cyc_i ? RESP    : IDLE;
            RD_REQ:  next_state = wb_cyc_i ? RD_DATA : IDLE;
            RD_DATA: next_state = wb_cyc_i ? RESP    : IDLE;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Next values for the registered outputs; selects fall back to all-high
    // so an abort or the RESP cycle always releases the macros.
    always_comb begin
        csb_d   = '1;
        web_d   = 1'b1;
        wmask_d = '0;
        addr_d  = sram_addr0;
        din_d   = sram_din0;
        dat_d   = wb_dat_o;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        bank_d  = bank_q;
        case (state)
            IDLE: begin
                if (req) begin
                    if (oor) begin
                        err_d = 1'b1;
                    end else begin
                        bank_d          = req_bank;
                        addr_d          = req_word;
                        csb_d[req_bank] = 1'b0;
                        if (wb_we_i) begin
                            web_d   = 1'b0;
                            wmask_d = {4'b0000, wb_sel_i};
                            din_d   = wb_dat_i;
                        end
                    end
                end
            end
            WR: begin
                ack_d = wb_cyc_i;
            end
            RD_REQ: begin
                // Keep the read presented for a second edge so data is stable
                // for both registered and combinational macro models.
                if (wb_cyc_i) csb_d = sram_csb0;
            end
            RD_DATA: begin
                if (wb_cyc_i) begin
                    ack_d = 1'b1;
                    dat_d = rdata;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sram_csb0   <= '1;
            sram_web0   <= 1'b1;
            sram_wmask0 <= '0;
            sram_addr0  <= '0;
            sram_din0   <= '0;
            wb_dat_o    <= '0;
            wb_ack_o    <= 1'b0;
            wb_err_o    <= 1'b0;
            bank_q      <= '0;
        end else begin
            sram_csb0   <= csb_d;
            sram_web0   <= web_d;
            sram_wmask0 <= wmask_d;
            sram_addr0  <= addr_d;
            sram_din0   <= din_d;
            wb_dat_o    <= dat_d;
            wb_ack_o    <= ack_d;
            wb_err_o    <= err_d;
            bank_q      <= bank_d;
        end
    end

endmodule

// File: tb/tb_wb_sram_ctrl.sv
// Bench for wb_sram_ctrl: behavioural macros on port 0, a word-level memory
// reference model, and per-scenario tasks with inline comparisons.
module tb_wb_sram_ctrl;
    import sram_pkg::*;

    localparam int          NB   = 2;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
    logic [31:0]   wb_adr_i = '0, wb_dat_i = '0;
    logic [3:0]    wb_sel_i = '0;
    logic [31:0]   wb_dat_o;
    logic          wb_ack_o, wb_err_o;
    logic [NB-1:0] sram_csb0;
    logic          sram_web0;
    logic [7:0]    sram_wmask0;
    logic [7:0]    sram_addr0;
    logic [31:0]   sram_din0;
    logic [NB*32-1:0] sram_dout0;
    state_t        fsm_state;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    wb_sram_ctrl #(.NUM_BANKS(NB), .ADDR_W(32), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
        .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
        .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0),
        .fsm_state(fsm_state)
    );

    // Behavioural macros: masked write on the clock edge, combinational read.
    logic [31:0] sram_mem [NB][256] = '{default: '0};

    always @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (!sram_csb0[b] && !sram_web0) begin
                for (int i = 0; i < 4; i++) begin
                    if (sram_wmask0[i]) sram_mem[b][sram_addr0][i*8 +: 8] = sram_din0[i*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        for (int b = 0; b < NB; b++) sram_dout0[b*32 +: 32] = sram_mem[b][sram_addr0];
    end

    // Edge monitors: tasks compare deltas, never reset these.
    int wr_cnt = 0, hi_mask_cnt = 0, both_cnt = 0;
    int sel_cnt [NB] = '{default: 0};

    always @(posedge clk) begin
        if (!sram_web0 && (sram_csb0 != '1)) wr_cnt++;
        if (sram_wmask0[7:4] != 4'h0) hi_mask_cnt++;
        if (wb_ack_o && wb_err_o) both_cnt++;
        for (int b = 0; b < NB; b++) if (!sram_csb0[b]) sel_cnt[b]++;
    end

    // Reference model: word-indexed memory with byte-select merge.
    logic [31:0] ref_mem [int];
    logic [31:0] exp_q [$];
    logic [31:0] exp_dat_o = '0;

    function automatic logic ref_oor(input logic [31:0] adr);
        return (adr < BASE) || (((adr - BASE) / 1024) >= NB);
    endfunction

    function automatic int ref_idx(input logic [31:0] adr);
        return int'((adr - BASE) / 4);
    endfunction

    function automatic logic [31:0] ref_rd(input int idx);
        return ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
    endfunction

    function automatic void ref_wr(input int idx, input logic [31:0] d, input logic [3:0] sel);
        logic [31:0] w;
        w = ref_rd(idx);
        for (int i = 0; i < 4; i++) if (sel[i]) w[i*8 +: 8] = d[i*8 +: 8];
        ref_mem[idx] = w;
    endfunction

    task automatic bus_idle();
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    endtask

    // One classic cycle; lat counts cycles after the accepting edge (0 = timeout).
    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, output logic [31:0] rdat,
                           output int lat, output logic was_err);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
        wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel;
        rdat = '0; lat = 0; was_err = 1'b0;
        @(posedge clk); #1;
        for (int n = 1; n <= 8; n++) begin
            if (lat == 0) begin
                if (wb_ack_o || wb_err_o) begin
                    lat = n; was_err = wb_err_o; rdat = wb_dat_o;
                end else begin
                    @(posedge clk); #1;
                end
            end
        end
        bus_idle();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (sram_csb0 !== '1) begin errors++; $display("FAIL reset_csb: got %b expected all ones", sram_csb0); end
        checks++; if (sram_web0 !== 1'b1 || sram_wmask0 !== 8'h00) begin errors++; $display("FAIL reset_web_mask: got web=%b mask=%h expected 1/00", sram_web0, sram_wmask0); end
        checks++; if (sram_addr0 !== 8'h00 || sram_din0 !== 32'h0) begin errors++; $display("FAIL reset_addr_din: got %h/%h expected 00/0", sram_addr0, sram_din0); end
        checks++; if (wb_ack_o !== 1'b0 || wb_err_o !== 1'b0 || wb_dat_o !== 32'h0) begin errors++; $display("FAIL reset_wb: got ack=%b err=%b dat=%h expected 0/0/0", wb_ack_o, wb_err_o, wb_dat_o); end
        checks++; if (fsm_state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d expected IDLE", fsm_state); end
        #3 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (sram_csb0 !== '1 || wb_ack_o !== 1'b0 || fsm_state !== IDLE) begin errors++; $display("FAIL post_reset_idle: got csb=%b ack=%b state=%0d expected all ones/0/IDLE", sram_csb0, wb_ack_o, fsm_state); end
    endtask

    task automatic test_basic();
        logic [31:0] rd; int lat; logic e;
        wb_xfer(1'b1, BASE + 32'h4, 32'hDEAD_BEEF, 4'hF, rd, lat, e);
        ref_wr(ref_idx(BASE + 32'h4), 32'hDEAD_BEEF, 4'hF);
        checks++; if (lat !== 2 || e !== 1'b0) begin errors++; $display("FAIL basic_wr_lat: got lat=%0d err=%b expected 2/0", lat, e); end
        wb_xfer(1'b0, BASE + 32'h4, 32'h0, 4'hF, rd, lat, e);
        exp_dat_o = 32'hDEAD_BEEF;
        checks++; if (lat !== 3 || e !== 1'b0) begin errors++; $display("FAIL basic_rd_lat: got lat=%0d err=%b expected 3/0", lat, e); end
        checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL basic_rd_data: got %h expected deadbeef", rd); end
    endtask

    task automatic test_byte_mask();
        logic [31:0] rd; int lat; logic e; int s0, s1;
        logic [31:0] adr;
        adr = BASE + 32'd1024 + 32'h10 * 4;
        s0 = sel_cnt[0]; s1 = sel_cnt[1];
        wb_xfer(1'b1, adr, 32'hFFFF_FFFF, 4'hF, rd, lat, e);
        ref_wr(ref_idx(adr), 32'hFFFF_FFFF, 4'hF);
        wb_xfer(1'b1, adr, 32'h0000_00AA, 4'b0001, rd, lat, e);
        ref_wr(ref_idx(adr), 32'h0000_00AA, 4'b0001);
        checks++; if (lat !== 2) begin errors++; $display("FAIL mask_wr_lat: got %0d expected 2", lat); end
        wb_xfer(1'b0, adr, 32'h0, 4'hF, rd, lat, e);
        exp_dat_o = 32'hFFFF_FFAA;
        checks++; if (rd !== 32'hFFFF_FFAA || lat !== 3) begin errors++; $display("FAIL mask_rd: got %h lat=%0d expected ffffffaa lat=3", rd, lat); end
        checks++; if (sel_cnt[0] - s0 !== 0 || sel_cnt[1] - s1 !== 4) begin errors++; $display("FAIL mask_bank_sel: got csb0 lows=%0d csb1 lows=%0d expected 0/4", sel_cnt[0] - s0, sel_cnt[1] - s1); end
    endtask

    task automatic test_error();
        logic [31:0] rd; int lat; logic e; int w0, s0, s1;
        w0 = wr_cnt; s0 = sel_cnt[0]; s1 = sel_cnt[1];
        wb_xfer(1'b1, BASE + NB * 1024, 32'h1234_5678, 4'hF, rd, lat, e);
        checks++; if (lat !== 1 || e !== 1'b1) begin errors++; $display("FAIL err_wr: got lat=%0d err=%b expected 1/1", lat, e); end
        checks++; if (wr_cnt !== w0 || sel_cnt[0] !== s0 || sel_cnt[1] !== s1) begin errors++; $display("FAIL err_no_csb: got %0d writes %0d/%0d selects expected none", wr_cnt - w0, sel_cnt[0] - s0, sel_cnt[1] - s1); end
        checks++; if (wb_dat_o !== exp_dat_o) begin errors++; $display("FAIL err_dat_hold: got %h expected %h", wb_dat_o, exp_dat_o); end
        wb_xfer(1'b0, BASE + NB * 1024 + 32'h1FC, 32'h0, 4'hF, rd, lat, e);
        checks++; if (lat !== 1 || e !== 1'b1) begin errors++; $display("FAIL err_rd: got lat=%0d err=%b expected 1/1", lat, e); end
        wb_xfer(1'b0, BASE, 32'h0, 4'hF, rd, lat, e);
        exp_dat_o = ref_rd(ref_idx(BASE));
        checks++; if (rd !== exp_dat_o) begin errors++; $display("FAIL err_mem_unchanged: got %h expected %h", rd, exp_dat_o); end
    endtask

    task automatic test_random();
        logic [31:0] rd, adr, dat, exp; int lat; logic e, we, oor; logic [3:0] sel;
        for (int k = 0; k < 40; k++) begin
            we  = 1'($urandom_range(0, 1));
            dat = $urandom;
            sel = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) adr = BASE + NB * 1024 + $urandom_range(0, 4095);
            else                           adr = BASE + $urandom_range(0, NB * 1024 - 1);
            oor = ref_oor(adr);
            if (!oor && !we) exp_q.push_back(ref_rd(ref_idx(adr)));
            wb_xfer(we, adr, dat, sel, rd, lat, e);
            if (oor) begin
                checks++; if (lat !== 1 || e !== 1'b1 || rd !== exp_dat_o) begin errors++; $display("FAIL rand_err[%0d]: got lat=%0d err=%b dat=%h expected 1/1/%h", k, lat, e, rd, exp_dat_o); end
            end else if (we) begin
                ref_wr(ref_idx(adr), dat, sel);
                checks++; if (lat !== 2 || e !== 1'b0) begin errors++; $display("FAIL rand_wr[%0d]: got lat=%0d err=%b expected 2/0", k, lat, e); end
            end else begin
                exp = exp_q.pop_front();
                exp_dat_o = exp;
                checks++; if (lat !== 3 || e !== 1'b0 || rd !== exp) begin errors++; $display("FAIL rand_rd[%0d]: got lat=%0d err=%b dat=%h expected 3/0/%h", k, lat, e, rd, exp); end
            end
        end
        checks++; if (both_cnt !== 0) begin errors++; $display("FAIL ack_err_overlap: got %0d expected 0", both_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, a1, a2; int lat, ack1, ack2, w0, m0; logic e;
        a1 = BASE + 32'h20; a2 = BASE + 32'h404;
        w0 = wr_cnt; m0 = hi_mask_cnt; ack1 = 0; ack2 = 0;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
        wb_adr_i = a1; wb_dat_i = 32'h1111_2222; wb_sel_i = 4'hF;
        @(posedge clk); #1;
        for (int n = 1; n <= 12; n++) begin
            if (ack2 == 0) begin
                if (wb_ack_o && ack1 == 0) begin
                    ack1 = n; wb_adr_i = a2; wb_dat_i = 32'h3333_4444; wb_sel_i = 4'b0110;
                end else if (wb_ack_o) begin
                    ack2 = n; bus_idle();
                end
                if (ack2 == 0) begin @(posedge clk); #1; end
            end
        end
        bus_idle();
        @(posedge clk); #1;
        ref_wr(ref_idx(a1), 32'h1111_2222, 4'hF);
        ref_wr(ref_idx(a2), 32'h3333_4444, 4'b0110);
        checks++; if (ack1 !== 2 || ack2 !== 5) begin errors++; $display("FAIL b2b_timing: got acks at %0d,%0d expected 2,5", ack1, ack2); end
        checks++; if (wr_cnt - w0 !== 2) begin errors++; $display("FAIL b2b_write_count: got %0d expected 2", wr_cnt - w0); end
        wb_xfer(1'b0, a2, 32'h0, 4'hF, rd, lat, e);
        exp_dat_o = ref_rd(ref_idx(a2));
        checks++; if (rd !== exp_dat_o) begin errors++; $display("FAIL b2b_readback: got %h expected %h", rd, exp_dat_o); end
        checks++; if (hi_mask_cnt !== m0 || hi_mask_cnt !== 0) begin errors++; $display("FAIL wmask_high: got %0d nonzero edges expected 0", hi_mask_cnt); end
    endtask

    task automatic test_abort();
        logic [31:0] rd, adr; int lat, spurious; logic e;
        adr = BASE + 32'h40C;
        wb_xfer(1'b1, adr, 32'hCAFE_F00D, 4'hF, rd, lat, e);
        ref_wr(ref_idx(adr), 32'hCAFE_F00D, 4'hF);
        // Abort a read while in RD_REQ.
        spurious = 0;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = adr;
        @(posedge clk); #1;
        bus_idle();
        for (int n = 0; n < 4; n++) begin
            @(posedge clk); #1;
            if (wb_ack_o || wb_err_o) spurious++;
        end
        checks++; if (spurious !== 0) begin errors++; $display("FAIL abort_rd_resp: got %0d ack/err cycles expected 0", spurious); end
        checks++; if (fsm_state !== IDLE || sram_csb0 !== '1) begin errors++; $display("FAIL abort_rd_idle: got state=%0d csb=%b expected IDLE/all ones", fsm_state, sram_csb0); end
        wb_xfer(1'b0, adr, 32'h0, 4'hF, rd, lat, e);
        exp_dat_o = ref_rd(ref_idx(adr));
        checks++; if (rd !== exp_dat_o || lat !== 3) begin errors++; $display("FAIL abort_rd_after: got %h lat=%0d expected %h lat=3", rd, lat, exp_dat_o); end
        // Abort a write while in WR: csb is already low, so it commits.
        spurious = 0;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
        wb_adr_i = adr; wb_dat_i = 32'h0BAD_0BAD; wb_sel_i = 4'b1100;
        @(posedge clk); #1;
        bus_idle();
        for (int n = 0; n < 3; n++) begin
            @(posedge clk); #1;
            if (wb_ack_o || wb_err_o) spurious++;
        end
        ref_wr(ref_idx(adr), 32'h0BAD_0BAD, 4'b1100);
        checks++; if (spurious !== 0 || fsm_state !== IDLE) begin errors++; $display("FAIL abort_wr: got %0d ack/err state=%0d expected 0/IDLE", spurious, fsm_state); end
        wb_xfer(1'b0, adr, 32'h0, 4'hF, rd, lat, e);
        exp_dat_o = ref_rd(ref_idx(adr));
        checks++; if (rd !== exp_dat_o) begin errors++; $display("FAIL abort_wr_commit: got %h expected %h", rd, exp_dat_o); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd, adr; int lat, spurious; logic e;
        adr = BASE + 32'h4;
        wb_xfer(1'b1, adr, 32'h5A5A_A5A5, 4'hF, rd, lat, e);
        ref_wr(ref_idx(adr), 32'h5A5A_A5A5, 4'hF);
        wb_xfer(1'b0, adr, 32'h0, 4'hF, rd, lat, e);
        checks++; if (wb_dat_o !== 32'h5A5A_A5A5) begin errors++; $display("FAIL rst_mid_pre: got %h expected 5a5aa5a5", wb_dat_o); end
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = adr;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (sram_csb0 !== '1 || wb_ack_o !== 1'b0 || wb_dat_o !== 32'h0 || sram_web0 !== 1'b1) begin errors++; $display("FAIL rst_mid_async: got csb=%b ack=%b dat=%h web=%b expected all ones/0/0/1", sram_csb0, wb_ack_o, wb_dat_o, sram_web0); end
        bus_idle();
        spurious = 0;
        for (int n = 0; n < 3; n++) begin
            @(posedge clk); #1;
            if (wb_ack_o || wb_err_o) spurious++;
        end
        #3 rst_n = 1'b1;
        for (int n = 0; n < 2; n++) begin
            @(posedge clk); #1;
            if (wb_ack_o || wb_err_o) spurious++;
        end
        checks++; if (spurious !== 0 || fsm_state !== IDLE) begin errors++; $display("FAIL rst_mid_no_ack: got %0d ack/err state=%0d expected 0/IDLE", spurious, fsm_state); end
        wb_xfer(1'b0, adr, 32'h0, 4'hF, rd, lat, e);
        checks++; if (rd !== ref_rd(ref_idx(adr)) || lat !== 3) begin errors++; $display("FAIL rst_mid_after: got %h lat=%0d expected %h lat=3", rd, lat, ref_rd(ref_idx(adr))); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_byte_mask();
        test_error();
        test_random();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
